// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the EX-stage handshake controller.
// State encoding, default result width and the timeout result fill.
package ex_ctrl_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic MC_TO_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ex_stage_ctrl_if.sv
// Handshake bundle between the EX controller and its neighbours.
// The slave modport is the controller; the master side is the pipeline.
interface ex_stage_ctrl_if
  import ex_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              ex_valid_i;
  logic              ex_is_mc_i;
  logic              flush_i;
  logic              mem_allowin_i;
  logic              ex_allowin_o;
  logic              ex_to_mem_valid_o;
  logic              mc_start_o;
  logic              mc_cancel_o;
  logic              mc_done_i;
  logic [DATA_W-1:0] mc_result_i;
  logic [DATA_W-1:0] ex_mc_result_o;
  logic              ex_mc_timeout_o;

  modport slave (
    input  ex_valid_i,
    input  ex_is_mc_i,
    input  flush_i,
    input  mem_allowin_i,
    input  mc_done_i,
    input  mc_result_i,
    output ex_allowin_o,
    output ex_to_mem_valid_o,
    output mc_start_o,
    output mc_cancel_o,
    output ex_mc_result_o,
    output ex_mc_timeout_o
  );

  modport master (
    output ex_valid_i,
    output ex_is_mc_i,
    output flush_i,
    output mem_allowin_i,
    output mc_done_i,
    output mc_result_i,
    input  ex_allowin_o,
    input  ex_to_mem_valid_o,
    input  mc_start_o,
    input  mc_cancel_o,
    input  ex_mc_result_o,
    input  ex_mc_timeout_o
  );

endinterface

// File: rtl/ex_mc_timer.sv
// Busy-cycle counter for the multi-cycle unit watchdog.
// expired is high in the MC_TIMEOUT-th enabled cycle after clear.
module ex_mc_timer #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MC_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // count busy cycles, restarting on each new launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = enable &
    (r_cnt == CW'(MC_TIMEOUT - 1));

endmodule

// File: rtl/ex_stage_ctrl.sv
// EX-stage valid/allowin controller sequencing the multi-cycle unit.
// Optional watchdog enabled by defining EX_MC_TIMEOUT_EN.
module ex_stage_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MC_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_stage_ctrl_if.slave  bus
);

  if (MC_TIMEOUT < 1) begin : g_bad_to
    $error("MC_TIMEOUT must be at least 1");
  end

  ex_state_e         r_state;
  ex_state_e         w_next;
  logic [DATA_W-1:0] r_res;
  logic              w_latch;
  logic              w_idle;
  logic              w_busy;
  logic              w_hold;
  logic              w_start;
  logic              w_exp;
  logic              w_to;
  logic              w_fin;
  logic              w_rdy;
  logic [DATA_W-1:0] w_ones;

  assign w_idle = (r_state == IDLE);
  assign w_busy = (r_state == BUSY);
  assign w_hold = (r_state == HOLD);
  assign w_ones = {DATA_W{MC_TO_BIT}};

  assign w_start = w_idle & bus.ex_valid_i &
    bus.ex_is_mc_i & ~bus.flush_i;

`ifdef EX_MC_TIMEOUT_EN
  ex_mc_timer #(
    .MC_TIMEOUT (MC_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_start),
    .enable  (w_busy),
    .expired (w_exp)
  );
`else
  assign w_exp = 1'b0;
`endif

  // a real done in the same cycle beats the watchdog
  assign w_to = w_busy & w_exp &
    ~bus.mc_done_i & ~bus.flush_i;

  assign w_fin = w_busy & (bus.mc_done_i | w_to);

  assign w_rdy = ~bus.ex_valid_i | ~bus.ex_is_mc_i |
    w_hold | w_fin;

  assign bus.ex_to_mem_valid_o = bus.ex_valid_i &
    w_rdy & ~bus.flush_i;
  assign bus.ex_allowin_o = ~bus.ex_valid_i |
    bus.flush_i | (w_rdy & bus.mem_allowin_i);
  assign bus.mc_start_o  = w_start;
  assign bus.mc_cancel_o = w_busy & (bus.flush_i | w_to);
  assign bus.ex_mc_timeout_o = w_to;
  assign bus.ex_mc_result_o = w_hold ? r_res :
    (w_to ? w_ones : bus.mc_result_i);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // capture the result when MEM cannot take it yet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
    end else if (w_latch) begin
      r_res <= w_to ? w_ones : bus.mc_result_i;
    end
  end

  // next state; flush overrides everything
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    if (bus.flush_i) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            w_next = BUSY;
          end
        end
        BUSY: begin
          if (w_fin) begin
            if (bus.mem_allowin_i) begin
              w_next = IDLE;
            end else begin
              w_next  = HOLD;
              w_latch = 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.mem_allowin_i) begin
            w_next = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule
